// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: AES InvMixColumns, one column per cycle; define INV_MIX_PARALLEL_EN to do all four columns in one BUSY cycle.
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         BUSY
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] src_q, src_d, res_q, res_d;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      x1[r] = c[31-8*r -: 8];
      x2[r] = xt(x1[r]);
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
    end
    // row r: 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3)
    for (int r = 0; r < 4; r++)
      o[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                     ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ x1[(r+1)%4])
                     ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ x1[(r+2)%4])
                     ^ (x8[(r+3)%4] ^ x1[(r+3)%4]);
    return o;
  endfunction
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    src_d     = src_q;
    res_d     = res_q;
    if (state_q == S_IDLE && IN_VALID) begin
      state_d   = S_BUSY;
      src_d     = IN_DATA;
      col_cnt_d = 2'd0;
    end
    if (state_q == S_BUSY) begin
`ifdef INV_MIX_PARALLEL_EN
      for (int c = 0; c < 4; c++) res_d[c*32 +: 32] = inv_col(src_q[c*32 +: 32]);
      state_d = S_DONE;
`else
      res_d[{~col_cnt_q, 5'd0} +: 32] = inv_col(src_q[{~col_cnt_q, 5'd0} +: 32]);
      col_cnt_d = col_cnt_q + 2'd1;
      state_d   = (col_cnt_q == 2'd3) ? S_DONE : S_BUSY;
`endif
    end
    if (state_q == S_DONE && OUT_READY) state_d = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_cnt_q <= 2'd0;
      src_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      src_q     <= src_d;
      res_q     <= res_d;
    end
  end
  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign BUSY      = (state_q == S_BUSY);
  assign OUT_DATA  = res_q;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: vector table, handshake corner cases and random states against a GF(2^8) reference model.
module tb_inv_mix_columns_seq;
`ifdef INV_MIX_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif
  localparam int PERIOD = LAT + 2;
  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [127:0] out_data;
  logic         busy;
  int checks = 0;
  int errors = 0;
  inv_mix_columns_seq dut (
    .clk(clk), .rst(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .BUSY(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
    logic [7:0] k [4];
    logic [7:0] a [4];
    logic [7:0] v;
    logic [127:0] o = '0;
    if (inv) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
    else     begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        v = 0;
        for (int j = 0; j < 4; j++) v ^= gmul(k[j], a[(r+j)%4]);
        o[127-32*c-8*r -: 8] = v;
      end
    end
    return o;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_txn(input logic [127:0] d, output logic [127:0] q, output int lat);
    int w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("in_ready_before_txn", in_ready, 1);
    in_valid = 1;
    in_data  = d;
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    q = out_data;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("in_ready_after_handshake", in_ready, 1);
  endtask
  typedef struct { logic [127:0] din; logic [127:0] dout; } vec_t;
  vec_t vecs [4];
  logic [127:0] q, held, x, d;
  logic [127:0] bb [2];
  logic [127:0] outs [2];
  int ocyc [2];
  int lat, sent, got;
  initial begin
    vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'hdb135345_f20a225c_01010101_d4d4d4d5};
    vecs[1] = '{128'h4d7ebdf8_c6c6c6c6_00000000_ffffffff, 128'h2d26314c_c6c6c6c6_00000000_ffffffff};
    vecs[2] = '{128'h0, 128'h0};
    vecs[3] = '{128'h01000000_00010000_00000100_00000001, 128'h0e090d0b_0b0e090d_0d0b0e09_090d0b0e};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_data", out_data, 0);
    out_ready = 1;
    repeat (2) @(negedge clk);
    chk("idle_out_ready_no_effect", {in_ready, out_valid, busy}, 3'b100);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i].din, q, lat);
      chk($sformatf("vec%0d_data", i), q, vecs[i].dout);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
    end
    // backpressure: hold DONE for 10 cycles, with an ignored input pulse
    in_valid = 1;
    in_data  = vecs[0].din;
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    held = out_data;
    chk("bp_data", held, vecs[0].dout);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_data  = vecs[3].din;
      @(negedge clk);
      chk("bp_state", {out_valid, in_ready, busy}, 3'b100);
      chk("bp_stable", out_data, held);
    end
    in_valid  = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp_release_idle", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    chk("bp_pulse_ignored", {in_ready, busy}, 2'b10);
    chk("bp_data_retained", out_data, held);
    // reset on the 2nd BUSY cycle
    in_valid = 1;
    in_data  = vecs[1].din;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("rst_mid_in_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_state", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_mid_data", out_data, 0);
    run_txn(vecs[1].din, q, lat);
    chk("after_rst_data", q, vecs[1].dout);
    // back-to-back with IN_VALID and OUT_READY held high
    bb[0] = {$urandom, $urandom, $urandom, $urandom};
    bb[1] = {$urandom, $urandom, $urandom, $urandom};
    sent = 0;
    got = 0;
    in_valid  = 1;
    in_data   = bb[0];
    out_ready = 1;
    for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
      if (out_valid) begin outs[got] = out_data; ocyc[got] = cyc; got++; end
      if (in_ready && sent < 2) sent++;
      @(negedge clk);
      in_valid = (sent < 2);
      in_data  = bb[sent % 2];
    end
    in_valid  = 0;
    out_ready = 0;
    chk("b2b_count", got, 2);
    chk("b2b_first", outs[0], mix_model(bb[0], 1));
    chk("b2b_second", outs[1], mix_model(bb[1], 1));
    chk("b2b_period", ocyc[1] - ocyc[0], PERIOD);
    repeat (2) @(negedge clk);
    // random states: direct model and forward/inverse round trip
    for (int i = 0; i < 20; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      d = (i % 2) ? mix_model(x, 0) : x;
      run_txn(d, q, lat);
      chk("rand_data", q, (i % 2) ? x : mix_model(x, 1));
      chk("rand_latency", lat, LAT);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Iterative AES InvMixColumns engine for the decryption datapath: accepts one 128-bit state with a valid/ready handshake and computes the GF(2^8) inverse column mix. It processes one 32-bit column per clock and holds the result until the downstream stage takes it. It pairs with the combinational forward MixColumns stage used on the encryption side, with identical byte and column ordering, so that inv_mix_columns_seq(MixColumns(x)) = x.

## Interface
Parameters: none.
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset, synchronous, active-high
- IN_VALID  input  1  IN_DATA holds a state to be accepted
- IN_READY  output  1  block can accept a state (high only in IDLE)
- IN_DATA  input  128  state in; column c = bits [127-32c : 96-32c]; top byte of each column is row 0
- OUT_VALID  output  1  OUT_DATA holds a finished result
- OUT_READY  input  1  downstream accepts OUT_DATA
- OUT_DATA  output  128  inverse-mixed state, same layout as IN_DATA
- BUSY  output  1  high in BUSY state

## Operation
- Per column (a0,a1,a2,a3), with a0 the top byte: out_r = 0e·a_r ^ 0b·a_(r+1) ^ 0d·a_(r+2) ^ 09·a_(r+3), indices mod 4.
- Multiplication is in GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11B). It is built from an xtime chain: 09=x8^x1, 0b=x8^x2^x1, 0d=x8^x4^x1, 0e=x8^x4^x2.
- FSM states:
  - IDLE: IN_READY=1. If IN_VALID, latch IN_DATA into the source register, clear the column counter, go to BUSY.
  - BUSY: each cycle, compute column col_cnt (0 first = bits [127:96]) from the source register and write it into the result register slice. col_cnt increments; at col_cnt==3, go to DONE and col_cnt wraps to 0.
  - DONE: OUT_VALID=1. When OUT_READY is high, go to IDLE.
- OUT_DATA is driven directly from the result register. It is stable from OUT_VALID rise until the handshake completes and retains its value after it.
- IN_VALID in BUSY or DONE is ignored. The upstream must hold the state until IN_READY.
- There is no same-cycle DONE→accept bypass. IN_READY reasserts the cycle after the output handshake.

## Timing
- Reset (rst high at a clk edge): state=IDLE, IN_READY=1, OUT_VALID=0, BUSY=0, OUT_DATA=128'h0, col_cnt=0.
- Reset mid-operation aborts the computation. The partial result is discarded and OUT_DATA returns to 0.
- Latency, iterative build: input accepted at edge N; BUSY is high after edges N..N+3; OUT_VALID rises after edge N+4.
- Throughput, iterative build, with OUT_READY held high: one state per 6 cycles (IDLE, 4×BUSY, DONE).
- OUT_READY high in IDLE or BUSY has no effect.
- OUT_READY low in DONE holds the block in DONE indefinitely with outputs unchanged.

## Configuration
- INV_MIX_PARALLEL_EN:
  - Defined: four column units are instantiated and BUSY lasts exactly one cycle, computing all columns. OUT_VALID rises after edge N+1. col_cnt is unused and reads 0.
  - Undefined (default): one shared column unit, 4 BUSY cycles as above.
- Handshake, reset values and results are identical in both builds. Only BUSY duration and latency differ.

## Test plan
- Reset, then idle: IN_READY=1, OUT_VALID=0, OUT_DATA=0.
- IN_DATA=8e4da1bc_9fdc589d_01010101_d5d5d7d6 with OUT_READY=1 → OUT_DATA=db135345_f20a225c_01010101_d4d4d4d5. OUT_VALID rises 4 cycles after acceptance (1 with INV_MIX_PARALLEL_EN).
- Round-trip: IN_DATA=MixColumns(2d26314c_c6c6c6c6_00000000_ffffffff)=4d7ebdf8_c6c6c6c6_00000000_ffffffff → OUT_DATA=2d26314c_c6c6c6c6_00000000_ffffffff.
- Backpressure: OUT_READY=0 for 10 cycles in DONE → OUT_VALID stays 1, OUT_DATA stable, IN_READY=0. A new IN_VALID pulse during this window is not accepted. OUT_READY=1 → IDLE next cycle.
- Reset asserted on the 2nd BUSY cycle → next cycle IDLE, OUT_DATA=0, OUT_VALID=0. The following transaction still produces the correct result.
- Back-to-back: IN_VALID held high and OUT_READY held high across two states → both results correct, in order, one state per 6 cycles (3 in parallel build).
